pwm_deadtime: RTL
=================

Name: pwm_deadtime

Overview:
Downstream stage of the PWM generator. Takes the single-ended pwm_out stream and drives a complementary half-bridge pair (high-side/low-side gate enables). Inserts a programmable dead time on every transition so both switches are never on together. Adds a latched fault shutdown and glitch suppression for pulses shorter than the dead time.

Parameters:
DT_WIDTH, 8, width of the dead-time count in clk_i cycles (max dead time 2^DT_WIDTH-1)

Ports:
clk_i  input  1  system clock, all logic on rising edge
rstn_i  input  1  synchronous active-low reset, sampled on rising clk_i
en_i  input  1  stage enable; low forces both outputs inactive
pwm_i  input  1  PWM stream from the generator (pwm_out)
dead_time_i  input  DT_WIDTH  dead time in cycles; sampled on entry to a dead-time phase
fault_i  input  1  external fault, active high
clear_fault_i  input  1  one-cycle request to leave the fault state
out_hi_o  output  1  high-side gate enable (registered)
out_lo_o  output  1  low-side gate enable (registered)
dt_active_o  output  1  high while in a dead-time phase (registered)
fault_o  output  1  latched fault flag (registered)

Behaviour:
- Reset (rstn_i=0 at rising edge): state IDLE, pwm_q=0, dt_cnt=0; out_hi_o=0, out_lo_o=0, dt_active_o=0, fault_o=0. Reset mid-dead-time or mid-fault aborts immediately.
- pwm_i registered once into pwm_q. State and all outputs are registered from next-state decode.
- States: IDLE, HI_ON, DT_H2L, LO_ON, DT_L2H, FAULT.
- Output decode: HI_ON -> hi=1,lo=0; LO_ON -> hi=0,lo=1; DT_* -> both 0, dt_active=1; IDLE/FAULT -> both 0.
- Priority per cycle: fault_i > en_i low > normal transitions.
- Any state, fault_i=1: -> FAULT, fault_o=1 next edge. FAULT left only when clear_fault_i=1 and fault_i=0 in the same cycle -> IDLE, fault_o=0. clear_fault_i while fault_i=1: ignored.
- en_i=0 (no fault): -> IDLE.
- IDLE, en_i=1: pwm_q=1 -> DT_L2H; pwm_q=0 -> DT_H2L (dead time applied on enable).
- HI_ON, pwm_q=0 -> DT_H2L. LO_ON, pwm_q=1 -> DT_L2H.
- Entering DT_*: dt_cnt loads dead_time_i-1. While in DT_*: decrement; when dt_cnt==0 exit to target (DT_L2H->HI_ON, DT_H2L->LO_ON). Both outputs low for exactly dead_time_i cycles.
- dead_time_i==0: DT state skipped; switch direct HI_ON<->LO_ON (outputs never overlap, since they come from one registered state).
- Glitch suppression: in DT_L2H with pwm_q=0 -> return to LO_ON next edge; in DT_H2L with pwm_q=1 -> return to HI_ON. Pulses shorter than the dead time never reach an output.
- Latency: pwm_i change before edge N -> pwm_q at N -> old output drops at N+1 -> new output asserts at N+1+dead_time_i.
- dead_time_i changes during a DT phase do not affect the current phase.

Optional Feature:
PWM_DT_POLARITY_EN: adds inputs hi_pol_i and lo_pol_i (1 bit each). Outputs are out_hi_o = hi_reg ^ hi_pol_i and out_lo_o = lo_reg ^ lo_pol_i, so the inactive level equals the polarity bit (including in reset, IDLE, DT and FAULT). Without the macro, the ports are absent and the outputs are active-high as above.

Test Plan:
- Reset with pwm_i=1, en_i=1 -> all outputs 0. Release; first edge pwm_q=1, next edge DT_L2H with dead_time_i=4 -> out_hi_o=1 exactly 4 cycles later.
- Steady pwm_i toggling every 20 cycles, dead_time_i=3 -> each edge shows exactly 3 cycles with both outputs 0 and dt_active_o=1; hi and lo never both 1.
- In LO_ON, dead_time_i=5, 2-cycle pwm_i high pulse -> out_hi_o stays 0, out_lo_o drops for 2 cycles then returns to 1.
- dead_time_i=0, pwm_i toggling -> outputs swap on the same edge with no overlap and no zero gap.
- In HI_ON, assert fault_i for 1 cycle -> next edge both outputs 0, fault_o=1. clear_fault_i while fault_i=1 -> stays in FAULT. clear_fault_i with fault_i=0 -> IDLE, then dead-time re-entry.
- Mid-DT (count 2 of 6), drop rstn_i -> next edge all outputs 0, state IDLE; en_i=0 in HI_ON -> IDLE next edge.

Source files
------------

// File: rtl/pwm_deadtime_if.sv
// pwm_deadtime_if: control/status bundle between the PWM generator side and the
// dead-time stage. The master modport drives the controls and the slave modport
// (the dead-time stage) drives the gate enables and status flags.
// Optional PWM_DT_POLARITY_EN adds the per-output polarity select bits.
interface pwm_deadtime_if #(
    parameter int DT_WIDTH = 8
);
    logic                en_i;
    logic                pwm_i;
    logic [DT_WIDTH-1:0] dead_time_i;
    logic                fault_i;
    logic                clear_fault_i;
    logic                out_hi_o;
    logic                out_lo_o;
    logic                dt_active_o;
    logic                fault_o;
`ifdef PWM_DT_POLARITY_EN
    logic                hi_pol_i;
    logic                lo_pol_i;
`endif

`ifdef PWM_DT_POLARITY_EN
    modport master (
        output en_i, pwm_i, dead_time_i, fault_i, clear_fault_i, hi_pol_i, lo_pol_i,
        input  out_hi_o, out_lo_o, dt_active_o, fault_o
    );
    modport slave (
        input  en_i, pwm_i, dead_time_i, fault_i, clear_fault_i, hi_pol_i, lo_pol_i,
        output out_hi_o, out_lo_o, dt_active_o, fault_o
    );
`else
    modport master (
        output en_i, pwm_i, dead_time_i, fault_i, clear_fault_i,
        input  out_hi_o, out_lo_o, dt_active_o, fault_o
    );
    modport slave (
        input  en_i, pwm_i, dead_time_i, fault_i, clear_fault_i,
        output out_hi_o, out_lo_o, dt_active_o, fault_o
    );
`endif
endinterface

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: turns a single-ended PWM stream into a complementary half-bridge
// gate pair with programmable dead time, short-pulse suppression and a latched
// fault shutdown. Optional macro PWM_DT_POLARITY_EN makes each output's inactive
// level selectable through hi_pol_i / lo_pol_i.
module pwm_deadtime #(
    parameter int DT_WIDTH = 8
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    pwm_deadtime_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        HI_ON  = 3'd1,
        DT_H2L = 3'd2,
        LO_ON  = 3'd3,
        DT_L2H = 3'd4,
        FAULT  = 3'd5
    } state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] cnt_q, cnt_d;
    logic                pwm_q;
    logic                valid_q;
    logic                hi_q, lo_q, dt_q, fault_q;
    logic                dt_zero;
    logic [DT_WIDTH-1:0] dt_load;

    assign dt_zero = (bus.dead_time_i == '0);
    assign dt_load = bus.dead_time_i - 1'b1;

    // Input sample of the PWM stream; valid_q marks that pwm_q holds a real
    // sample rather than its reset value, so IDLE never acts on stale data.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            pwm_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            pwm_q   <= bus.pwm_i;
            valid_q <= 1'b1;
        end
    end

    // Next-state decode: fault beats disable, disable beats normal switching.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.fault_i) begin
            state_d = FAULT;
        end else if (state_q == FAULT) begin
            if (bus.clear_fault_i) begin
                state_d = IDLE;
            end
        end else if (!bus.en_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (valid_q) begin
                        if (pwm_q) begin
                            state_d = dt_zero ? HI_ON : DT_L2H;
                        end else begin
                            state_d = dt_zero ? LO_ON : DT_H2L;
                        end
                        cnt_d = dt_load;
                    end
                end
                HI_ON: begin
                    if (!pwm_q) begin
                        state_d = dt_zero ? LO_ON : DT_H2L;
                        cnt_d   = dt_load;
                    end
                end
                LO_ON: begin
                    if (pwm_q) begin
                        state_d = dt_zero ? HI_ON : DT_L2H;
                        cnt_d   = dt_load;
                    end
                end
                DT_L2H: begin
                    if (!pwm_q) begin
                        state_d = LO_ON;
                    end else if (cnt_q == '0) begin
                        state_d = HI_ON;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                DT_H2L: begin
                    if (pwm_q) begin
                        state_d = HI_ON;
                    end else if (cnt_q == '0) begin
                        state_d = LO_ON;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, dead-time counter and output registers, all decoded from next state
    // so both gate enables come from one register update and can never overlap.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hi_q    <= 1'b0;
            lo_q    <= 1'b0;
            dt_q    <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= (state_d == HI_ON);
            lo_q    <= (state_d == LO_ON);
            dt_q    <= (state_d == DT_H2L) || (state_d == DT_L2H);
            fault_q <= (state_d == FAULT);
        end
    end

`ifdef PWM_DT_POLARITY_EN
    assign bus.out_hi_o = hi_q ^ bus.hi_pol_i;
    assign bus.out_lo_o = lo_q ^ bus.lo_pol_i;
`else
    assign bus.out_hi_o = hi_q;
    assign bus.out_lo_o = lo_q;
`endif
    assign bus.dt_active_o = dt_q;
    assign bus.fault_o     = fault_q;

endmodule
